// File: rtl/layer_fc_par_if.sv
// rtl/layer_fc_par_if.sv - stream, config and status bundle for layer_fc_par
// Purpose: groups every handshake/bus signal of layer_fc_par into one interface.
// Signals:
//   s_valid/s_ready/s_data   input vector stream, x[0..N-1] in order
//   m_valid/m_ready/m_data   output stream, y[0..M-1] in row order
//   cfg_we/cfg_sel/cfg_addr/cfg_data  weight (sel=0) / bias (sel=1) RAM writes
//   busy                     layer is mid-operation; config writes are ignored
// Modports: slave = the layer itself, master = whoever drives it.
interface layer_fc_par_if #(
  parameter int T  = 20,
  parameter int CA = 8
);
  logic          s_valid;
  logic          s_ready;
  logic [T-1:0]  s_data;
  logic          m_valid;
  logic          m_ready;
  logic [T-1:0]  m_data;
  logic          cfg_we;
  logic          cfg_sel;
  logic [CA-1:0] cfg_addr;
  logic [T-1:0]  cfg_data;
  logic          busy;

  modport slave (
    input  s_valid, s_data, m_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    output s_ready, m_valid, m_data, busy
  );

  modport master (
    output s_valid, s_data, m_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  s_ready, m_valid, m_data, busy
  );
endinterface

// File: rtl/layer_fc_par.sv
// rtl/layer_fc_par.sv - fully connected layer y = act(W*x + b) with P MAC lanes
// Purpose: loads an N-word input vector, then computes M outputs P rows at a
// time from runtime-written weight/bias RAMs, streaming results in row order.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    layer_fc_par_if.slave: input stream, output stream, config, busy
module layer_fc_par #(
  parameter int M    = 16,
  parameter int N    = 12,
  parameter int T    = 20,
  parameter int P    = 4,
  parameter int FRAC = 0,
  parameter int RELU = 1
) (
  input logic           clk,
  input logic           reset,
  layer_fc_par_if.slave bus
);
  localparam int G  = M / P;
  localparam int WD = G * N;
  localparam int AW = 2 * T + $clog2(N + 1);
  localparam int CW = $clog2(N + 2);
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam int WW = (WD > 1) ? $clog2(WD) : 1;
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};

  typedef enum logic [1:0] {LOAD_X, COMPUTE, OUTPUT} state_t;
  state_t state_q, state_d;

  logic [XW-1:0] xcnt_q;
  logic [CW-1:0] cnt_q;
  logic [GW-1:0] g_q;
  logic [LW-1:0] lane_q;
  logic          s_rdy, m_vld, is_busy, x_hs, m_hs;

  logic signed [T-1:0]   wram [P][WD];
  logic signed [T-1:0]   bram [P][G];
  logic signed [T-1:0]   xram [N];
  logic signed [T-1:0]   x_q;
  logic signed [T-1:0]   w_q [P];
  logic signed [T-1:0]   b_q [P];
  logic signed [2*T-1:0] prod_q [P];
  logic signed [AW-1:0]  acc_q [P];

  // Config write decode: weight address r*N+c maps to bank r%P, local (r/P)*N+c.
  int            wr_row, wr_col;
  logic [LW-1:0] wr_bank, b_bank;
  logic [WW-1:0] wr_loc;
  logic [GW-1:0] b_row;
  logic          cfg_ok, w_hit, b_hit;

  always_comb begin
    wr_row  = int'(bus.cfg_addr) / N;
    wr_col  = int'(bus.cfg_addr) % N;
    wr_bank = LW'(wr_row % P);
    wr_loc  = WW'((wr_row / P) * N + wr_col);
    b_bank  = LW'(int'(bus.cfg_addr) % P);
    b_row   = GW'(int'(bus.cfg_addr) / P);
    // The first x word raises busy, so a write in that same cycle is dropped.
    cfg_ok  = bus.cfg_we && !is_busy && !x_hs;
    w_hit   = cfg_ok && !bus.cfg_sel && (int'(bus.cfg_addr) < M * N);
    b_hit   = cfg_ok && bus.cfg_sel && (int'(bus.cfg_addr) < M);
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_hit) wram[wr_bank][wr_loc] <= bus.cfg_data;
    if (b_hit) bram[b_bank][b_row] <= bus.cfg_data;
    if (x_hs)  xram[xcnt_q] <= bus.s_data;
  end

  // Read pipeline: cnt_q=c issues the read of column c, the registered product
  // of column c is ready at cnt_q=c+2, so adds run for cnt_q in 2..N+1.
  logic [XW-1:0] rd_c;
  logic [WW-1:0] rd_w;
  assign rd_c = (cnt_q < CW'(N)) ? XW'(cnt_q) : '0;
  assign rd_w = WW'(int'(g_q) * N + int'(rd_c));

  always_ff @(posedge clk) begin
    x_q <= xram[rd_c];
    for (int l = 0; l < P; l++) begin
      w_q[l]    <= wram[l][rd_w];
      b_q[l]    <= bram[l][g_q];
      prod_q[l] <= x_q * w_q[l];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < P; l++) acc_q[l] <= '0;
    end else if (state_q == COMPUTE) begin
      for (int l = 0; l < P; l++) begin
        if (cnt_q == CW'(1))
          acc_q[l] <= {{(AW-T){b_q[l][T-1]}}, b_q[l]} <<< FRAC;
        else if (cnt_q >= CW'(2))
          acc_q[l] <= acc_q[l] + {{(AW-2*T){prod_q[l][2*T-1]}}, prod_q[l]};
      end
    end
  end

  function automatic logic [T-1:0] post(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    logic [T-1:0]         r;
    s = a >>> FRAC;
    if (s > SAT_HI)      r = SAT_HI[T-1:0];
    else if (s < SAT_LO) r = SAT_LO[T-1:0];
    else                 r = s[T-1:0];
    if (RELU != 0 && r[T-1]) r = '0;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    s_rdy   = 1'b0;
    m_vld   = 1'b0;
    is_busy = 1'b1;
    x_hs    = 1'b0;
    m_hs    = 1'b0;
    case (state_q)
      LOAD_X: begin
        s_rdy   = !reset;
        is_busy = (xcnt_q != '0);
        x_hs    = bus.s_valid && s_rdy;
        if (x_hs && xcnt_q == XW'(N - 1)) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (cnt_q == CW'(N + 1)) state_d = OUTPUT;
      end
      OUTPUT: begin
        m_vld = 1'b1;
        m_hs  = bus.m_ready;
        if (m_hs && lane_q == LW'(P - 1))
          state_d = (g_q == GW'(G - 1)) ? LOAD_X : COMPUTE;
      end
      default: state_d = LOAD_X;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_X;
      xcnt_q  <= '0;
      cnt_q   <= '0;
      g_q     <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      if (x_hs) xcnt_q <= (xcnt_q == XW'(N - 1)) ? '0 : xcnt_q + XW'(1);
      if (state_q == COMPUTE) cnt_q <= (state_d == OUTPUT) ? '0 : cnt_q + CW'(1);
      if (m_hs) begin
        lane_q <= (lane_q == LW'(P - 1)) ? '0 : lane_q + LW'(1);
        if (lane_q == LW'(P - 1)) g_q <= (g_q == GW'(G - 1)) ? '0 : g_q + GW'(1);
      end
    end
  end

  assign bus.s_ready = s_rdy;
  assign bus.m_valid = m_vld;
  assign bus.busy    = is_busy;
  assign bus.m_data  = m_vld ? post(acc_q[lane_q]) : '0;
endmodule

// File: tb/tb_layer_fc_par.sv
// tb/tb_layer_fc_par.sv - scoreboard bench for layer_fc_par (two configurations in lockstep)
`timescale 1ns/1ps
module tb_layer_fc_par;
  localparam int M  = 16;
  localparam int N  = 12;
  localparam int T  = 20;
  localparam int P  = 4;
  localparam int CA = $clog2(M * N);
  localparam longint HI = (longint'(1) <<< (T - 1)) - 1;
  localparam longint LO = -(longint'(1) <<< (T - 1));

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          s_valid, m_ready, cfg_we, cfg_sel;
  logic [T-1:0]  s_data, cfg_data;
  logic [CA-1:0] cfg_addr;

  layer_fc_par_if #(.T(T), .CA(CA)) bus0 ();
  layer_fc_par_if #(.T(T), .CA(CA)) bus1 ();

  assign bus0.s_valid = s_valid;  assign bus1.s_valid = s_valid;
  assign bus0.s_data = s_data;    assign bus1.s_data = s_data;
  assign bus0.m_ready = m_ready;  assign bus1.m_ready = m_ready;
  assign bus0.cfg_we = cfg_we;    assign bus1.cfg_we = cfg_we;
  assign bus0.cfg_sel = cfg_sel;  assign bus1.cfg_sel = cfg_sel;
  assign bus0.cfg_addr = cfg_addr; assign bus1.cfg_addr = cfg_addr;
  assign bus0.cfg_data = cfg_data; assign bus1.cfg_data = cfg_data;

  layer_fc_par #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .RELU(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  layer_fc_par #(.M(M), .N(N), .T(T), .P(P), .FRAC(4), .RELU(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  // Reference model state
  longint wm [M][N];
  longint bm [M];
  longint xv [N];
  int relu_p [2] = '{1, 0};
  int frac_p [2] = '{0, 4};
  longint expq [2][$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  function automatic longint ref_y(input int d, input int r);
    longint acc;
    acc = bm[r] <<< frac_p[d];
    for (int c = 0; c < N; c++) acc += wm[r][c] * xv[c];
    acc = acc >>> frac_p[d];
    if (acc > HI) acc = HI;
    if (acc < LO) acc = LO;
    if (relu_p[d] != 0 && acc < 0) acc = 0;
    return acc;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge
  logic mv [2], msr [2];
  logic [T-1:0] md [2];
  always_comb begin
    mv[0] = bus0.m_valid;  mv[1] = bus1.m_valid;
    msr[0] = bus0.s_ready; msr[1] = bus1.s_ready;
    md[0] = bus0.m_data;   md[1] = bus1.m_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ref_cyc [2], xhs [2], ohs [2];
  bit pv [2], pstall [2], armed [2];
  logic [T-1:0] pdat [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        xhs[d] = 0; ohs[d] = 0; pv[d] = 0; pstall[d] = 0; armed[d] = 0;
      end else begin
        if (expq[d].size() > 0) chk("s_ready_low_while_pending", msr[d], 0);
        if (pstall[d]) begin
          chk("stall_valid_held", mv[d], 1);
          chk("stall_data_held", md[d], pdat[d]);
        end
        if (mv[d] && !pv[d] && armed[d]) begin
          chk("first_valid_latency", cyc - ref_cyc[d], N + 3);
          armed[d] = 0;
        end
        if (mv[d] && m_ready) begin
          chk("output_expected", expq[d].size() > 0, 1);
          if (expq[d].size() > 0) chk($sformatf("y_dut%0d", d), $signed(md[d]), expq[d].pop_front());
          ohs[d]++;
          if (ohs[d] % P == 0 && ohs[d] % M != 0) begin
            ref_cyc[d] = cyc; armed[d] = 1;
          end
        end
        if (s_valid && msr[d]) begin
          xhs[d]++;
          if (xhs[d] % N == 0) begin
            ref_cyc[d] = cyc; armed[d] = 1;
          end
        end
        pstall[d] = mv[d] && !m_ready;
        pdat[d] = md[d];
        pv[d] = mv[d];
      end
    end
  end

  // Downstream ready pattern: 0 always, 1 one cycle in three, 2 random
  int rdy_mode = 0;
  initial begin
    int rc = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rc++;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = (rc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic cfg_write(input bit sel, input int addr, input longint val, input bit apply);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = CA'(addr); cfg_data = T'(val);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (apply) begin
      if (sel) bm[addr] = val;
      else wm[addr / N][addr % N] = val;
    end
  endtask

  task automatic load(input int kind);
    longint v;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        case (kind)
          0: v = (c == r % N) ? 1 : 0;
          1: v = 0;
          2: v = HI;
          3: v = 16;
          default: v = int'($urandom_range(0, 255)) - 128;
        endcase
        cfg_write(1'b0, r * N + c, v, 1'b1);
      end
    for (int r = 0; r < M; r++) begin
      case (kind)
        1: v = r - 8;
        4: v = int'($urandom_range(0, 2047)) - 1024;
        default: v = 0;
      endcase
      cfg_write(1'b1, r, v, 1'b1);
    end
  endtask

  task automatic send_vec(input longint xs [N], input bit cfg_on_first);
    int n;
    for (int i = 0; i < N; i++) xv[i] = xs[i];
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1; s_data = T'(xs[i]);
      if (i == 0 && cfg_on_first) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = T'(777);
      end
      n = 0;
      forever begin
        @(negedge clk);
        if (bus0.s_ready || n > 2000) break;
        n++;
      end
      if (n > 2000) begin
        chk("s_ready_timeout", bus0.s_ready, 1);
        s_valid = 1'b0; cfg_we = 1'b0;
        return;
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
    s_valid = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < M; r++) expq[d].push_back(ref_y(d, r));
  endtask

  task automatic drain();
    int n = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0) && n < 5000) begin
      @(posedge clk); n++;
    end
    chk("drain_left", expq[0].size() + expq[1].size(), 0);
    expq[0].delete(); expq[1].delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    longint xs [N];
    int n;
    s_valid = 1'b0; s_data = '0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", bus0.s_ready, 0);
    chk("rst_m_valid", bus0.m_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", bus0.s_ready, 1);
    chk("post_rst_m_valid", bus1.m_valid, 0);
    chk("post_rst_m_data", bus0.m_data, 0);
    chk("post_rst_busy", bus0.busy, 0);
    @(posedge clk); #1;

    // Selection matrix, x = 1..12
    load(0);
    for (int i = 0; i < N; i++) xs[i] = i + 1;
    send_vec(xs, 1'b0); drain();
    // Same vector under 1-in-3 backpressure
    rdy_mode = 1;
    send_vec(xs, 1'b0); drain();

    // Bias / ReLU, with out-of-range writes that must not land
    load(1);
    cfg_write(1'b1, 16, 5, 1'b0);
    cfg_write(1'b0, 200, 5, 1'b0);
    rdy_mode = 2;
    for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 4095)) - 2048;
    send_vec(xs, 1'b0); drain();

    // Saturation both ways
    load(2);
    for (int i = 0; i < N; i++) xs[i] = HI;
    send_vec(xs, 1'b0); drain();
    for (int i = 0; i < N; i++) xs[i] = LO;
    send_vec(xs, 1'b0); drain();

    // Fractional shift; then a config write on the first x word is dropped
    load(3);
    rdy_mode = 0;
    for (int i = 0; i < N; i++) xs[i] = 1;
    send_vec(xs, 1'b0); drain();
    send_vec(xs, 1'b1); drain();

    // Random weights, bias and inputs
    load(4);
    rdy_mode = 2;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 4095)) - 2048;
      send_vec(xs, 1'b0); drain();
    end

    // Abort in group 2 COMPUTE after an ignored busy-time write, then recompute
    send_vec(xs, 1'b0);
    n = 0;
    while (expq[0].size() > 8 && n < 5000) begin
      @(posedge clk); n++;
    end
    chk("reach_group2", expq[0].size(), 8);
    #1;
    cfg_write(1'b0, 0, 12345, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_s_ready", bus0.s_ready, 0);
    @(posedge clk); #1;
    expq[0].delete(); expq[1].delete();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_m_valid", bus0.m_valid, 0);
    chk("abort_s_ready", bus1.s_ready, 1);
    chk("abort_busy", bus0.busy, 0);
    @(posedge clk); #1;
    send_vec(xs, 1'b0); drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
